// File: rtl/deser_sout.sv
// deser_sout: serial-to-parallel receiver for the shift register's S_OUT.
// Assembles WIDTH-bit words (MSB- or LSB-first, chosen per word by DIR),
// optionally checks a trailing even-parity slot, and queues completed
// words in a 2-entry FIFO drained by VALID/READY.
// Ports:
//   CLK, RESET_L    clock, async active-low reset
//   ENB, DIR, S_IN  sample enable, bit order (0=MSB-first), serial data
//   CLR             synchronous clear / realign (highest priority)
//   READY           consumer accepts head word
//   Q_OUT, PAR_ERR  head word and its parity error (0 when empty)
//   VALID, COUNT    FIFO not empty, occupancy 0..2
//   OVF             sticky overflow (word dropped on full FIFO)
module deser_sout #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic             CLR,
  input  logic             READY,
  output logic [WIDTH-1:0] Q_OUT,
  output logic             VALID,
  output logic             PAR_ERR,
  output logic             OVF,
  output logic [1:0]       COUNT
);

  localparam int unsigned SLOTS = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam int unsigned CW    = $clog2(SLOTS);
  localparam logic        PEN   = (PARITY_EN != 0);

  // Frame assembly state
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_dir;
  logic             r_par;

  // FIFO state
  logic [WIDTH-1:0] r_mem  [2];
  logic             r_perr [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             r_ovf;

  logic             w_first;
  logic             w_last;
  logic             w_dir;
  logic [WIDTH-1:0] w_shift;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic [WIDTH-1:0] w_push_data;
  logic             w_push_perr;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CW'(SLOTS - 1));
  // DIR is taken live at slot 0, then the latched copy holds for the word
  assign w_dir   = w_first ? DIR : r_dir;
  assign w_shift = w_dir ? {S_IN, r_word[WIDTH-1:1]}
                         : {r_word[WIDTH-2:0], S_IN};

  assign w_push      = ENB && w_last;
  // With parity the final slot is the parity bit, so the word is already complete
  assign w_push_data = PEN ? r_word : w_shift;
  assign w_push_perr = PEN && (r_par ^ S_IN);

  assign w_full    = (r_count == 2'd2);
  assign w_pop     = (r_count != 2'd0) && READY;
  assign w_push_ok = w_push && (!w_full || w_pop);

  // Bit counter, partial word, latched direction and running parity
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_dir  <= 1'b0;
      r_par  <= 1'b0;
    end else if (CLR) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_dir  <= 1'b0;
      r_par  <= 1'b0;
    end else if (ENB) begin
      if (w_last) begin
        r_cnt  <= '0;
        r_word <= '0;
        r_par  <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_word <= w_shift;
        r_par  <= w_first ? S_IN : (r_par ^ S_IN);
      end
      if (w_first) begin
        r_dir <= DIR;
      end
    end
  end

  // Two-entry FIFO; when full with a concurrent pop, the write lands in the
  // slot being vacated (wr_ptr == rd_ptr when full)
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i]  <= '0;
        r_perr[i] <= 1'b0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ovf    <= 1'b0;
    end else if (CLR) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i]  <= '0;
        r_perr[i] <= 1'b0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr]  <= w_push_data;
        r_perr[r_wr_ptr] <= w_push_perr;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  // Outputs derived from registered FIFO state only
  assign VALID   = (r_count != 2'd0);
  assign COUNT   = r_count;
  assign OVF     = r_ovf;
  assign Q_OUT   = VALID ? r_mem[r_rd_ptr] : '0;
  assign PAR_ERR = VALID ? r_perr[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_deser_sout.sv
// Directed testbench for deser_sout: one 8-bit no-parity instance and one
// 8-bit parity instance share all inputs.
module tb_deser_sout;

  logic       clk;
  logic       rst_n;
  logic       enb;
  logic       dir;
  logic       s_in;
  logic       clr;
  logic       ready;

  logic [7:0] q;
  logic       valid;
  logic       perr;
  logic       ovf;
  logic [1:0] cnt;

  logic [7:0] qp;
  logic       validp;
  logic       perrp;
  logic       ovfp;
  logic [1:0] cntp;

  int n_checks;
  int n_errors;

  deser_sout #(.WIDTH(8), .PARITY_EN(0)) dut (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb), .DIR(dir), .S_IN(s_in),
    .CLR(clr), .READY(ready), .Q_OUT(q), .VALID(valid), .PAR_ERR(perr),
    .OVF(ovf), .COUNT(cnt)
  );

  deser_sout #(.WIDTH(8), .PARITY_EN(1)) dut_p (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb), .DIR(dir), .S_IN(s_in),
    .CLR(clr), .READY(ready), .Q_OUT(qp), .VALID(validp), .PAR_ERR(perrp),
    .OVF(ovfp), .COUNT(cntp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends bits[n-1] first; returns at the negedge after the last sampled edge
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      enb  = 1'b1;
      s_in = bits[i];
    end
    @(negedge clk);
    enb = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enb = 1'b0; dir = 1'b0; s_in = 1'b0; clr = 1'b0; ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (q !== 8'h00 || valid !== 1'b0 || perr !== 1'b0 || ovf !== 1'b0 || cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_state: q=%h valid=%b perr=%b ovf=%b cnt=%0d, want all 0", q, valid, perr, ovf, cnt);
    end
  endtask

  task automatic test_msb_first();
    dir = 1'b0; ready = 1'b1;
    send_bits(16'h00C1, 8);
    n_checks++;
    if (valid !== 1'b1 || q !== 8'hC1 || cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL msb_first: valid=%b q=%h cnt=%0d, want 1 c1 1", valid, q, cnt);
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || cnt !== 2'd0 || q !== 8'h00) begin
      n_errors++;
      $display("FAIL msb_drain: valid=%b cnt=%0d q=%h, want 0 0 00", valid, cnt, q);
    end
  endtask

  task automatic test_lsb_first();
    dir = 1'b1; ready = 1'b1;
    send_bits(16'h00C1, 8);
    n_checks++;
    if (valid !== 1'b1 || q !== 8'h83) begin
      n_errors++;
      $display("FAIL lsb_first: valid=%b q=%h, want 1 83", valid, q);
    end
    @(negedge clk);
  endtask

  task automatic test_dir_toggle();
    dir = 1'b1; ready = 1'b1;
    send_bits(16'h000C, 4);
    dir = 1'b0;
    send_bits(16'h0001, 4);
    n_checks++;
    if (valid !== 1'b1 || q !== 8'h83) begin
      n_errors++;
      $display("FAIL dir_toggle: valid=%b q=%h, want 1 83", valid, q);
    end
    @(negedge clk);
    // Next word must use the new DIR=0
    send_bits(16'h00C1, 8);
    n_checks++;
    if (valid !== 1'b1 || q !== 8'hC1) begin
      n_errors++;
      $display("FAIL dir_next_word: valid=%b q=%h, want 1 c1", valid, q);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    dir = 1'b0; ready = 1'b0;
    send_bits(16'h0011, 8);
    send_bits(16'h0022, 8);
    n_checks++;
    if (cnt !== 2'd2 || ovf !== 1'b0 || q !== 8'h11) begin
      n_errors++;
      $display("FAIL ovf_pre: cnt=%0d ovf=%b q=%h, want 2 0 11", cnt, ovf, q);
    end
    send_bits(16'h0033, 8);
    n_checks++;
    if (cnt !== 2'd2 || ovf !== 1'b1 || q !== 8'h11) begin
      n_errors++;
      $display("FAIL ovf_set: cnt=%0d ovf=%b q=%h, want 2 1 11", cnt, ovf, q);
    end
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cnt !== 2'd1 || q !== 8'h22) begin
      n_errors++;
      $display("FAIL ovf_drain1: cnt=%0d q=%h, want 1 22", cnt, q);
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || cnt !== 2'd0 || q !== 8'h00 || ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_drain2: valid=%b cnt=%0d q=%h ovf=%b, want 0 0 00 1", valid, cnt, q, ovf);
    end
    do_clr();
    n_checks++;
    if (ovf !== 1'b0 || cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL ovf_clr: ovf=%b cnt=%0d, want 0 0", ovf, cnt);
    end
  endtask

  task automatic test_full_pop();
    dir = 1'b0; ready = 1'b0;
    send_bits(16'h00A5, 8);
    send_bits(16'h003C, 8);
    send_bits(16'h004B, 7);
    // Final bit of 8'h96 with READY high on the same edge
    @(negedge clk);
    enb = 1'b1; s_in = 1'b0; ready = 1'b1;
    @(negedge clk);
    enb = 1'b0; ready = 1'b0;
    n_checks++;
    if (cnt !== 2'd2 || ovf !== 1'b0 || q !== 8'h3C) begin
      n_errors++;
      $display("FAIL full_pop: cnt=%0d ovf=%b q=%h, want 2 0 3c", cnt, ovf, q);
    end
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cnt !== 2'd1 || q !== 8'h96) begin
      n_errors++;
      $display("FAIL full_pop_tail: cnt=%0d q=%h, want 1 96", cnt, q);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_enb_gap();
    dir = 1'b0; ready = 1'b0;
    send_bits(16'h005A, 8);
    send_bits(16'h0016, 5);
    n_checks++;
    if (cnt !== 2'd1 || q !== 8'h5A) begin
      n_errors++;
      $display("FAIL pre_reset: cnt=%0d q=%h, want 1 5a", cnt, q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (q !== 8'h00 || valid !== 1'b0 || perr !== 1'b0 || ovf !== 1'b0 || cnt !== 2'd0) begin
      n_errors++;
      $display("FAIL async_reset: q=%h valid=%b perr=%b ovf=%b cnt=%0d, want all 0", q, valid, perr, ovf, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    send_bits(16'h0006, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_in = ~s_in;
    end
    send_bits(16'h0001, 5);
    n_checks++;
    if (valid !== 1'b1 || q !== 8'hC1) begin
      n_errors++;
      $display("FAIL enb_gap: valid=%b q=%h, want 1 c1", valid, q);
    end
    @(negedge clk);
  endtask

  task automatic test_parity();
    dir = 1'b0; ready = 1'b1;
    do_clr();
    send_bits(16'h0183, 9);
    n_checks++;
    if (validp !== 1'b1 || qp !== 8'hC1 || perrp !== 1'b0) begin
      n_errors++;
      $display("FAIL parity_ok: valid=%b q=%h perr=%b, want 1 c1 0", validp, qp, perrp);
    end
    @(negedge clk);
    send_bits(16'h0182, 9);
    n_checks++;
    if (validp !== 1'b1 || qp !== 8'hC1 || perrp !== 1'b1) begin
      n_errors++;
      $display("FAIL parity_err: valid=%b q=%h perr=%b, want 1 c1 1", validp, qp, perrp);
    end
    @(negedge clk);
    n_checks++;
    if (validp !== 1'b0 || perrp !== 1'b0 || qp !== 8'h00) begin
      n_errors++;
      $display("FAIL parity_empty: valid=%b perr=%b q=%h, want 0 0 00", validp, perrp, qp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_dir_toggle();
    test_overflow();
    test_full_pop();
    test_reset_enb_gap();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
